fetch_stage: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of the decode stage and drives its 16-bit inst.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC, one-at-a-time word fetch from imem, 1-entry skid and IF/ID register feeding decode.
// Latency: an imem response in cycle N is on o_inst in cycle N+1; the next request is visible no earlier than N+1.
// Backpressure: i_stall freezes IF/ID; one returning word parks in the skid and no request issues while it is full.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [15:0] i_br_target,
  input  logic        i_halt,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_inst,
  output logic [15:0] o_inst_pc,
  output logic        o_inst_valid,
  output logic        o_halted
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_req;
  logic [15:0] r_addr;
  logic [15:0] r_inst;
  logic [15:0] r_inst_pc;
  logic        r_inst_vld;
  logic        r_skid_vld;
  logic [15:0] r_skid_dat;
  logic [15:0] r_skid_pc;
  logic        r_out;
  logic        r_disc;
  logic        r_halted;

  logic        w_resp;
  logic        w_word;
  logic        w_busy;
  logic        w_issue;
  logic [15:0] w_pc_inc;
  logic [15:0] w_issue_addr;

  // A response only counts while a request is outstanding; stray strobes are ignored.
  assign w_resp       = i_imem_valid && r_out;
  assign w_word       = w_resp && !r_disc;
  assign w_busy       = r_out && !w_resp;
  assign w_pc_inc     = r_pc + 16'd1;
  // Issue in the same cycle the previous word returns, using the already-advanced PC.
  assign w_issue      = (r_state == ST_RUN) && !i_br_taken && !i_halt && !i_stall &&
                        !r_skid_vld && !w_busy;
  assign w_issue_addr = w_word ? w_pc_inc : r_pc;

  // Fetch FSM with PC, request, skid and IF/ID registers; redirect beats halt, halt beats stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= 16'h0000;
      r_inst     <= NOP_INST;
      r_inst_pc  <= 16'h0000;
      r_inst_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_skid_dat <= 16'h0000;
      r_skid_pc  <= 16'h0000;
      r_out      <= 1'b0;
      r_disc     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_req <= 1'b0;
      r_out <= w_busy;
      if (r_state == ST_HALTED) begin
        // Parked: late responses only retire the outstanding flag.
        r_halted <= 1'b1;
      end else if (i_br_taken) begin
        r_pc       <= i_br_target;
        r_inst     <= NOP_INST;
        r_inst_vld <= 1'b0;
        r_skid_vld <= 1'b0;
        r_disc     <= w_busy;
      end else if (i_halt) begin
        r_state    <= ST_HALTED;
        r_halted   <= 1'b1;
        r_inst     <= NOP_INST;
        r_inst_vld <= 1'b0;
        r_skid_vld <= 1'b0;
        r_disc     <= w_busy;
      end else begin
        if (w_resp) r_disc <= 1'b0;
        if (w_word) r_pc <= w_pc_inc;
        if (i_stall) begin
          if (w_word && !r_inst_vld) begin
            r_inst     <= i_imem_rdata;
            r_inst_pc  <= r_pc;
            r_inst_vld <= 1'b1;
          end else if (w_word) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= i_imem_rdata;
            r_skid_pc  <= r_pc;
          end
        end else if (r_skid_vld) begin
          r_inst     <= r_skid_dat;
          r_inst_pc  <= r_skid_pc;
          r_inst_vld <= 1'b1;
          r_skid_vld <= 1'b0;
        end else if (w_word) begin
          r_inst     <= i_imem_rdata;
          r_inst_pc  <= r_pc;
          r_inst_vld <= 1'b1;
        end else begin
          r_inst     <= NOP_INST;
          r_inst_vld <= 1'b0;
        end
        if (w_issue) begin
          r_req  <= 1'b1;
          r_addr <= w_issue_addr;
          r_out  <= 1'b1;
        end
      end
    end
  end

  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_addr;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_inst_valid = r_inst_vld;
  assign o_halted     = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural queue model, imem responder with variable latency, directed phases plus random stall/redirect traffic.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, br_taken, halt, imem_valid;
  logic [15:0] br_target, imem_rdata;
  logic        imem_req, inst_valid, halted;
  logic [15:0] imem_addr, inst, inst_pc;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INST(16'h0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_br_taken(br_taken),
    .i_br_target(br_target), .i_halt(halt), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_valid(imem_valid), .i_imem_rdata(imem_rdata), .o_inst(inst), .o_inst_pc(inst_pc),
    .o_inst_valid(inst_valid), .o_halted(halted));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pc; logic [15:0] dat; } ent_t;

  // model state: fetch buffer as a queue (front = what decode sees, second = parked word)
  ent_t        m_buf[$];
  logic [15:0] m_pc, m_addr;
  logic        m_req, m_out, m_disc, m_halt;

  int total = 0, bad = 0, cyc = 0;
  int mem_cnt = 0, mem_lat = 1;
  logic rand_lat = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [15:0] req_log[$];
  int          req_cyc[$];
  ent_t        inst_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_pc = 16'h0000; m_addr = 16'h0000;
    m_req = 1'b0; m_out = 1'b0; m_disc = 1'b0; m_halt = 1'b0;
  endtask

  // next-cycle model state from current inputs
  task automatic model_step();
    logic resp, word, skid_full;
    ent_t e;
    resp  = imem_valid && m_out;
    m_req = 1'b0;
    if (m_halt) begin
      m_out = m_out && !resp;
    end else if (br_taken) begin
      m_out = m_out && !resp; m_disc = m_out; m_pc = br_target; m_buf.delete();
    end else if (halt) begin
      m_out = m_out && !resp; m_disc = m_out; m_halt = 1'b1; m_buf.delete();
    end else begin
      word = resp && !m_disc;
      if (resp) begin m_disc = 1'b0; m_out = 1'b0; end
      skid_full = (m_buf.size() == 2);
      if (!stall && m_buf.size() > 0) void'(m_buf.pop_front());
      if (word) begin e.pc = m_pc; e.dat = imem_rdata; m_buf.push_back(e); m_pc = m_pc + 16'd1; end
      if (!stall && !skid_full && !m_out) begin m_req = 1'b1; m_addr = m_pc; m_out = 1'b1; end
    end
  endtask

  // one clock cycle, entered and left at a falling edge
  task automatic cycle(input logic s, input logic b, input logic [15:0] t, input logic h);
    ent_t e;
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("inst_valid", inst_valid, m_buf.size() > 0);
    chk("inst", inst, (m_buf.size() > 0) ? m_buf[0].dat : 16'h0000);
    if (m_buf.size() > 0) chk("inst_pc", inst_pc, m_buf[0].pc);
    chk("halted", halted, m_halt);
    if (imem_req) begin req_log.push_back(imem_addr); req_cyc.push_back(cyc); end
    if (inst_valid && (inst_log.size() == 0 || inst_log[$].pc != inst_pc)) begin
      e.pc = inst_pc; e.dat = inst; inst_log.push_back(e);
    end
    imem_valid = 1'b0;
    imem_rdata = 16'($urandom);
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin imem_valid = 1'b1; imem_rdata = mem_addr + 16'h1000; end
    end
    stall = s; br_taken = b; br_target = t; halt = h;
    if (m_req) begin
      mem_cnt  = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
      mem_addr = m_addr;
    end
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic ok;
    logic [15:0] x;
    int nreq;
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; halt = 1'b0; br_target = 16'h0;
    imem_valid = 1'b0; imem_rdata = 16'h0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_pc", inst_pc, 16'h0000);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    rst_n = 1'b1;

    // streaming with 1-cycle memory
    mem_lat = 1;
    idle(9);
    ok = (req_log.size() >= 3) && (inst_log.size() >= 2);
    chk("stream_counts", ok, 1'b1);
    if (ok) begin
      chk("stream_addr0", req_log[0], 16'h0000);
      chk("stream_addr1", req_log[1], 16'h0001);
      chk("stream_addr2", req_log[2], 16'h0002);
      chk("stream_gap", req_cyc[1] - req_cyc[0], 2);
      chk("stream_inst0", {inst_log[0].pc, inst_log[0].dat}, 32'h0000_1000);
      chk("stream_inst1", {inst_log[1].pc, inst_log[1].dat}, 32'h0001_1001);
    end

    // stall for 4 cycles while a word is returning into a full IF/ID
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_req && m_buf.size() == 1) ok = 1'b1; else idle(1);
    end
    chk("stall_setup", ok, 1'b1);
    x = m_buf[0].pc;
    nreq = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        chk("stall_hold_pc", inst_pc, x);
        if (imem_req) nreq++;
      end
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
    end
    chk("stall_no_req", nreq, 0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("skid_out_valid", inst_valid, 1'b1);
    chk("skid_out_pc", inst_pc, x + 16'd1);
    chk("skid_out_inst", inst, x + 16'd1 + 16'h1000);
    idle(6);

    // redirect to 0x0040 while a 3-cycle fetch is in flight
    mem_lat = 3;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_req) ok = 1'b1; else idle(1);
    end
    chk("br_setup", ok, 1'b1);
    idle(1);
    cycle(1'b0, 1'b1, 16'h0040, 1'b0);
    req_log.delete();
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (inst_valid) ok = 1'b1; else idle(1);
    end
    chk("br_arrive", ok, 1'b1);
    chk("br_first_pc", inst_pc, 16'h0040);
    chk("br_first_inst", inst, 16'h1040);
    chk("br_first_addr", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'h0040);

    // redirect and stall together: redirect wins
    mem_lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_buf.size() > 0) ok = 1'b1; else idle(1);
    end
    chk("brst_setup", ok, 1'b1);
    cycle(1'b1, 1'b1, 16'h0080, 1'b0);
    req_log.delete();
    chk("brst_flush", inst_valid, 1'b0);
    for (int i = 0; i < 20 && req_log.size() == 0; i++) idle(1);
    chk("brst_addr", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'h0080);

    // PC wrap
    idle(4);
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
    req_log.delete();
    for (int i = 0; i < 30 && req_log.size() < 2; i++) idle(1);
    chk("wrap_addr0", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'hFFFF);
    chk("wrap_addr1", (req_log.size() > 1) ? req_log[1] : 16'hDEAD, 16'h0000);

    // random stall/redirect traffic with random memory latency
    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, 16'($urandom), 1'b0);
    rand_lat = 1'b0; mem_lat = 1;
    idle(6);

    // async reset pulse with a fetch in flight; its response lands after reset
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_req) ok = 1'b1; else idle(1);
    end
    chk("rstmid_setup", ok, 1'b1);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", imem_req, 1'b0);
    chk("rstmid_valid", inst_valid, 1'b0);
    chk("rstmid_inst", inst, 16'h0000);
    chk("rstmid_addr", imem_addr, 16'h0000);
    #1;
    rst_n = 1'b1;
    model_reset();
    req_log.delete();
    for (int i = 0; i < 20 && req_log.size() == 0; i++) idle(1);
    chk("rstmid_refetch", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'h0000);
    idle(5);

    // halt: stays halted, no requests, redirect ignored
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    chk("halt_next", halted, 1'b1);
    req_log.delete();
    idle(20);
    chk("halt_no_req", req_log.size(), 0);
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(5);
    chk("halt_br_ignored", req_log.size(), 0);
    chk("halt_stays", halted, 1'b1);
    chk("halt_no_inst", inst_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
